// File: rtl/noc_pkg.sv
// noc_pkg: flit field positions, route label codes and default flit width
package noc_pkg;
  localparam int DATASIZE_DEF = 40;
  localparam int SRC_HI = 39;
  localparam int SRC_LO = 36;
  localparam int DST_HI = 35;
  localparam int DST_LO = 32;
  localparam int TS_HI = 31;
  localparam int TS_LO = 24;
  localparam int PAY_HI = 23;
  localparam int PAY_LO = 2;
  localparam int TYPE_HI = 1;
  localparam int TYPE_LO = 0;
  typedef enum logic [3:0] {
    LBL_IDLE = 4'd0,
    LBL_L    = 4'd1,
    LBL_N    = 4'd2,
    LBL_E    = 4'd3,
    LBL_S    = 4'd4,
    LBL_W    = 4'd5
  } label_t;
endpackage

// File: rtl/input_port_if.sv
// input_port_if: upstream flit link plus allocator-facing head/label signals
interface input_port_if #(parameter int DATASIZE = 40);
  logic [DATASIZE-1:0] data_in;
  logic                data_valid_in;
  logic                full;
  logic                ready;
  logic [3:0]          label;
  logic [DATASIZE-1:0] data_out;
  modport master (output data_in, data_valid_in, ready, input full, label, data_out);
  modport slave  (input data_in, data_valid_in, ready, output full, label, data_out);
endinterface

// File: rtl/route_xy.sv
// route_xy: dimension-order XY route request from a 4-bit destination address
module route_xy import noc_pkg::*; #(
  parameter int X_ID = 0,
  parameter int Y_ID = 0
) (
  input  logic [3:0] dst,
  output logic [3:0] label
);
  logic [1:0] x, y, xi, yi;
  always_comb begin
    x = dst[3:2];
    y = dst[1:0];
    xi = 2'(X_ID);
    yi = 2'(Y_ID);
    label = x > xi ? LBL_E : x < xi ? LBL_W : y > yi ? LBL_S : y < yi ? LBL_N : LBL_L;
  end
endmodule

// File: rtl/input_port.sv
// input_port: FWFT flit buffer with XY route label; IP_DROP_CNT_EN adds a saturating drop counter
module input_port import noc_pkg::*; #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int X_ID     = 0,
  parameter int Y_ID     = 0
) (
  input logic         clk,
  input logic         rst_n,
  input_port_if.slave link
`ifdef IP_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH:0]      count;
  logic [DATASIZE-1:0] head;
  logic [3:0]          route;
  logic                wr, pop, empty;
  always_comb begin
    empty = count == '0;
    link.full = count == (WIDTH+1)'(DEPTH);
    wr = link.data_valid_in & ~link.full;
    pop = link.ready & ~empty;
    head = mem[rd_ptr];
    link.data_out = empty ? '0 : head;
    link.label = empty ? LBL_IDLE : route;
  end
  route_xy #(.X_ID(X_ID), .Y_ID(Y_ID)) u_route (
    .dst   (head[DST_HI:DST_LO]),
    .label (route)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (WIDTH+1)'(wr) - (WIDTH+1)'(pop);
    end
  // storage is left uncleared on reset; count gates every read
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= link.data_in;
`ifdef IP_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (link.data_valid_in && link.full && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_input_port.sv
// tb_input_port: scoreboard bench for input_port against a queue-based reference model
module tb_input_port;
  logic clk, rst_n;
  input_port_if #(.DATASIZE(40)) bus ();
`ifdef IP_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  input_port #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .X_ID(1), .Y_ID(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (bus)
`ifdef IP_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );
  typedef struct {
    logic [39:0] d;
    logic [3:0]  l;
    logic        f;
`ifdef IP_DROP_CNT_EN
    logic [7:0]  dc;
`endif
  } exp_t;
  exp_t exp_q[$];
  logic [39:0] mq[$];
  int drops, errors, checks;
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [3:0] route(input logic [3:0] dst);
    int x, y;
    x = int'(dst[3:2]);
    y = int'(dst[1:0]);
    if (x > 1) return 4'd3;
    if (x < 1) return 4'd5;
    if (y > 1) return 4'd4;
    if (y < 1) return 4'd2;
    return 4'd1;
  endfunction
  function automatic logic [39:0] mk(input logic [3:0] dst);
    logic [39:0] f;
    f = {$urandom, $urandom};
    f[35:32] = dst;
    return f;
  endfunction
  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic step(input logic v, input logic [39:0] d, input logic r);
    exp_t e;
    bit w, p;
    bus.data_valid_in = v;
    bus.data_in = d;
    bus.ready = r;
    @(posedge clk);
    #1;
    w = v && mq.size() < 8;
    p = r && mq.size() > 0;
    if (v && !w && drops < 255) drops++;
    if (p) void'(mq.pop_front());
    if (w) mq.push_back(d);
    e.d = mq.size() > 0 ? mq[0] : 40'd0;
    e.l = mq.size() > 0 ? route(mq[0][35:32]) : 4'd0;
    e.f = mq.size() == 8;
`ifdef IP_DROP_CNT_EN
    e.dc = 8'(drops);
`endif
    exp_q.push_back(e);
  endtask
  task automatic idle();
    bus.data_valid_in = 0;
    bus.data_in = '0;
    bus.ready = 0;
  endtask
  task automatic reset_checks();
    chk("rst_full", 40'(bus.full), 40'd0);
    chk("rst_label", 40'(bus.label), 40'd0);
    chk("rst_data", bus.data_out, 40'd0);
`ifdef IP_DROP_CNT_EN
    chk("rst_drop", 40'(drop_cnt), 40'd0);
`endif
  endtask
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("data_out", bus.data_out, e.d);
      chk("label", 40'(bus.label), 40'(e.l));
      chk("full", 40'(bus.full), 40'(e.f));
`ifdef IP_DROP_CNT_EN
      chk("drop_cnt", 40'(drop_cnt), 40'(e.dc));
`endif
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    errors = 0;
    checks = 0;
    drops = 0;
    idle();
    rst_n = 0;
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    step(1, mk(4'b1001), 0);
    step(0, '0, 1);
    step(1, mk(4'b0101), 0);
    step(0, '0, 1);
    step(1, mk(4'b0100), 0);
    step(0, '0, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    for (int i = 0; i < 9; i++) step(1, mk(4'($urandom)), 0);
    for (int i = 0; i < 9; i++) step(0, '0, 1);
    for (int i = 0; i < 8; i++) step(1, mk(4'($urandom)), 0);
    step(1, mk(4'b0000), 1);
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, mk(4'($urandom)), 0);
    idle();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    reset_checks();
    mq.delete();
    drops = 0;
    @(negedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, mk(4'($urandom)), $urandom_range(0, 2) == 0);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 1) == 0, mk(4'($urandom)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1);
    idle();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_port.md
INPUT_PORT -- requirements
Module: input_port

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning buffer depth in flits (power of two).
REQ-002 SHALL have parameter WIDTH, default 3, meaning pointer width, log2(DEPTH).
REQ-003 SHALL have parameter DATASIZE, default 40, meaning flit width.
REQ-004 SHALL have parameter X_ID, default 0, meaning 2-bit router x coordinate.
REQ-005 SHALL have parameter Y_ID, default 0, meaning 2-bit router y coordinate.
REQ-006 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_in, input, DATASIZE, flit from the upstream link.
REQ-009 SHALL have port data_valid_in, input, 1, meaning data_in is valid this cycle.
REQ-010 SHALL have port full, output, 1, meaning the buffer holds DEPTH flits and the upstream must hold.
REQ-011 SHALL have port ready, input, 1, the switch allocator's grant; pops the head flit.
REQ-012 SHALL have port label, output, 4, meaning the route request for the head flit.
REQ-013 SHALL have port data_out, output, DATASIZE, the head flit.

Function
REQ-014 Flit layout SHALL be src[39:36], dst[35:32], timestamp[31:24], payload[23:2], type[1:0]; the address x is bits [3:2] and y is bits [1:0].
REQ-015 Buffer SHALL be a first-word-fall-through circular FIFO with write pointer, read pointer and a (WIDTH+1)-bit count.
REQ-016 A write SHALL occur when data_valid_in=1 and full=0; when full=1 the flit is discarded.
REQ-017 A pop SHALL occur when ready=1 and count>0; ready while empty is ignored.
REQ-018 A simultaneous write and pop SHALL leave count unchanged; when full, the write is still rejected in that cycle.
REQ-019 full SHALL be combinational from the registered count (count==DEPTH), so it has no combinational path from ready.
REQ-020 A flit written at edge n SHALL appear on data_out and label in the cycle after edge n (1-cycle latency), when the buffer was empty.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 label SHALL use XY routing on the head dst: 4'd0 = idle (empty); otherwise x_dst>X_ID gives 4'd3 E, x_dst<X_ID gives 4'd5 W, else y_dst>Y_ID gives 4'd4 S, y_dst<Y_ID gives 4'd2 N, else 4'd1 L.
REQ-023 data_out SHALL be all zeros and label SHALL be 4'd0 whenever count==0.
REQ-024 Every flit SHALL be routed independently; the type field SHALL pass through unmodified.

Reset
REQ-025 rst_n low SHALL immediately clear the pointers and count, giving full=0, label=4'd0 and data_out=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered flits; the buffer memory itself need not be cleared.

Configuration
REQ-027 With IP_DROP_CNT_EN defined, the block SHALL add the output drop_cnt[7:0]; it increments on each cycle with data_valid_in=1 and full=1, saturates at 255, and resets to 0.
REQ-028 With IP_DROP_CNT_EN undefined, the drop_cnt port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-029 The shared package noc_pkg SHALL hold the flit field bit positions, the label codes (IDLE/L/N/E/S/W) and the DATASIZE default.
REQ-030 Route computation SHALL be a combinational sub-module route_xy (inputs: dst and the X_ID/Y_ID parameters; output: label).

Verification
REQ-031 The bench SHALL cover: X_ID=1, Y_ID=1, write dst=4'b1001 (x2,y1) into an empty buffer -> next cycle label=4'd3 and data_out=flit.
REQ-032 The bench SHALL cover: write dst=4'b0101 (x1,y1) -> label=4'd1; write dst=4'b0100 (x1,y0) after that flit is popped -> label=4'd2.
REQ-033 The bench SHALL cover: 8 writes with ready=0 -> full=1 after the 8th; a 9th write is dropped; eight pops then return the 8 flits in order, with no 9th flit.
REQ-034 The bench SHALL cover: count=8 with data_valid_in=1 and ready=1 in the same cycle -> count=7 and the new flit is lost (drop_cnt+1 when enabled).
REQ-035 The bench SHALL cover: ready=1 while empty -> count stays 0 and label stays 4'd0.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-cycle with 5 flits buffered -> immediately count=0, full=0, label=4'd0, data_out=0.
